// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding word memory responder with fixed latency, byte enables and error checking
module dmem_responder #(
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    input  logic [3:0]  i_req_be,
    output logic        o_resp_valid,
    input  logic        i_resp_ready,
    output logic [31:0] o_resp_rdata,
    output logic        o_resp_err
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY > 1 ? LATENCY - 2 : 0);
    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [31:0] mem_q [2**DEPTH_LOG2];
    logic        accept, enter_resp, acc_we, acc_err;
    logic [31:0] acc_addr, acc_wdata;
    logic [3:0]  acc_be;
    logic [DEPTH_LOG2-1:0] idx;
    // With LATENCY=1 the access happens on the accept edge, so it uses the live request
    always_comb begin
        accept     = i_req_valid && state_q == IDLE;
        acc_we     = state_q == IDLE ? i_req_we : we_q;
        acc_addr   = state_q == IDLE ? i_req_addr : addr_q;
        acc_wdata  = state_q == IDLE ? i_req_wdata : wdata_q;
        acc_be     = state_q == IDLE ? i_req_be : be_q;
        idx        = acc_addr[DEPTH_LOG2+1:2];
        acc_err    = acc_addr[1:0] != 2'b00 || (acc_addr >> (DEPTH_LOG2 + 2)) != 32'd0;
        enter_resp = LATENCY == 1 ? accept : (state_q == WAIT && cnt_q == 4'd0);
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        unique case (state_q)
            IDLE: if (accept) begin
                state_d = LATENCY == 1 ? RESP : WAIT;
                cnt_d   = CNT_INIT;
                we_d    = i_req_we;
                addr_d  = i_req_addr;
                wdata_d = i_req_wdata;
                be_d    = i_req_be;
            end
            WAIT: begin
                state_d = cnt_q == 4'd0 ? RESP : WAIT;
                cnt_d   = cnt_q == 4'd0 ? 4'd0 : cnt_q - 4'd1;
            end
            RESP: state_d = i_resp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
        rdata_d = enter_resp ? ((acc_we || acc_err) ? 32'd0 : mem_q[idx]) : rdata_q;
        err_d   = enter_resp ? acc_err : err_q;
    end
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end
    // Storage survives reset; a reset on the commit edge suppresses the write
    always_ff @(posedge clk) begin
        if (rstn && enter_resp && acc_we && !acc_err)
            for (int k = 0; k < 4; k++)
                if (acc_be[k]) mem_q[idx][8*k +: 8] <= acc_wdata[8*k +: 8];
    end
    assign o_req_ready  = state_q == IDLE;
    assign o_resp_valid = state_q == RESP;
    assign o_resp_rdata = rdata_q;
    assign o_resp_err   = err_q;
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_LOG2, default 8, meaning log2 of the number of 32-bit words stored (256 words).
REQ-002 The block SHALL have parameter LATENCY, default 2, meaning cycles from request acceptance to response valid, with a legal range of 1..15.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port rstn, input, 1 bit: reset that is synchronous and active-low.
REQ-005 The block SHALL have port i_req_valid, input, 1 bit: the initiator presents a request.
REQ-006 The block SHALL have port o_req_ready, output, 1 bit: the responder can accept a request.
REQ-007 The block SHALL have port i_req_we, input, 1 bit: 1 selects write, 0 selects read.
REQ-008 The block SHALL have port i_req_addr, input, 32 bits: byte address.
REQ-009 The block SHALL have port i_req_wdata, input, 32 bits: write data.
REQ-010 The block SHALL have port i_req_be, input, 4 bits: byte enables for writes, where bit k enables byte k (bits [8k+7:8k]).
REQ-011 The block SHALL have port o_resp_valid, output, 1 bit: a response is presented.
REQ-012 The block SHALL have port i_resp_ready, input, 1 bit: the initiator accepts the response.
REQ-013 The block SHALL have port o_resp_rdata, output, 32 bits: read data; 0 for writes and errors.
REQ-014 The block SHALL have port o_resp_err, output, 1 bit: the access was rejected.

Function
REQ-015 The block SHALL implement a three-state FSM: IDLE, WAIT, RESP.
REQ-016 o_req_ready SHALL be 1 exactly when the state is IDLE; o_resp_valid SHALL be 1 exactly when the state is RESP.
REQ-017 A request SHALL be accepted on a rising edge where i_req_valid and o_req_ready are both 1; we, addr, wdata and be SHALL be captured at that edge.
REQ-018 After acceptance at edge E, o_resp_valid SHALL first be 1 in the cycle following edge E+LATENCY-1.
- LATENCY=1: IDLE goes directly to RESP.
- LATENCY>1: the FSM passes through WAIT, using a 4-bit down-counter.
REQ-019 The memory access (read capture or write commit) SHALL occur on the edge that enters RESP.
REQ-020 o_resp_rdata and o_resp_err SHALL remain stable while in RESP.
REQ-021 The block SHALL stay in RESP until i_resp_ready is 1 at an edge, then return to IDLE; i_resp_ready already high in the first RESP cycle SHALL complete the handshake at that edge.
REQ-022 The block SHALL allow only one outstanding transaction; i_req_valid outside IDLE SHALL be ignored, and i_req_* need not be held after acceptance.
REQ-023 The word index SHALL be i_req_addr[DEPTH_LOG2+1:2].
REQ-024 An error SHALL be raised (err=1, rdata=0, memory unchanged) for either of these:
- addr[1:0] != 0 (misaligned);
- addr[31:DEPTH_LOG2+2] != 0 (out of range).
REQ-025 A write SHALL update only the enabled bytes; be=4'b0000 SHALL leave memory unchanged, with err=0.
REQ-026 A read SHALL return the full 32-bit word, ignoring be.
REQ-027 A write response SHALL carry rdata=0 and err as computed.
REQ-028 Minimum spacing between accepted requests SHALL be LATENCY+1 cycles.

Reset
REQ-029 When rstn=0 at a rising edge, the next state SHALL be:
- state IDLE and counter 0;
- o_resp_valid=0, o_resp_rdata=0, o_resp_err=0;
- o_req_ready=1 (once rstn is released).
REQ-030 Reset SHALL take priority over every other event in the same cycle, including acceptance and response handshake.
REQ-031 Reset asserted in WAIT SHALL discard the pending write with memory unmodified; reset in RESP SHALL drop the response.
REQ-032 Memory array contents SHALL NOT be cleared by reset.

Verification
REQ-033 Write then read, LATENCY=2: write addr 0x10, wdata 0xDEADBEEF, be 4'hF, accepted at edge E -> o_resp_valid=1 after edge E+1 with err=0 and rdata=0; a subsequent read of 0x10 -> rdata 0xDEADBEEF, err=0.
REQ-034 Byte enables: after writing 0xDEADBEEF to 0x10, write 0x11223344 with be 4'b0101 -> a read of 0x10 returns 0xDE22BE44.
REQ-035 Errors:
- read of 0x13 -> err=1, rdata=0;
- write of 0x400 (DEPTH_LOG2=8) -> err=1, and a read of 0x0 is unchanged.
REQ-036 Backpressure: i_resp_ready held at 0 for 5 cycles in RESP -> o_resp_valid stays 1, rdata stable, o_req_ready stays 0; i_req_valid pulses during that time are ignored.
REQ-037 Reset mid-op: write 0xCAFEF00D to 0x20 accepted, rstn=0 at the next edge (WAIT) -> IDLE, o_resp_valid=0; a later read of 0x20 returns its prior value.
REQ-038 LATENCY=1: back-to-back requests with i_resp_ready tied to 1 -> acceptances every 2 cycles, each response valid for exactly 1 cycle.
